// File: rtl/obstacle_pkg.sv
// ---------------------------------------------------------------------------
// obstacle_pkg
// Shared definitions for the obstacle sequencer slice:
//   - FSM state encoding (state_t), exported on the top's dbg_state port
//   - one-hot obstacle select codes and the "nothing selected" code
//   - LFSR seed and tap mask used by the RANDOM_ORDER_EN build
//   - onehot_idx(): converts a one-hot select code back to its index
// ---------------------------------------------------------------------------
package obstacle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAUSE     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] OBST_LASERS = 4'b0001;
  localparam logic [3:0] OBST_SPIKES = 4'b0010;
  localparam logic [3:0] OBST_BLOCKS = 4'b0100;
  localparam logic [3:0] OBST_BALLS  = 4'b1000;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left:
  // feedback is the XOR of bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [1:0] onehot_idx(input logic [3:0] code);
    onehot_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (code[i]) onehot_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/obstacle_collision.sv
// ---------------------------------------------------------------------------
// obstacle_collision
// Registered player-box vs obstacle-pixel compare with an invulnerability
// window. A pixel at (0,x) or (x,0) means "no pixel" and never hits.
// Ports:
//   i_pclk        pixel clock
//   i_rst         synchronous active-low reset
//   i_clr         synchronous clear (game abort): drops hit and the window
//   i_en          compare enabled (sequencer in an active gameplay state)
//   i_obstacle_x/y  OR-ed obstacle pixel coordinate, 12 bits each
//   i_player_x/y    player box top-left corner, 12 bits each
//   o_hit         1-cycle pulse, one cycle after an accepted collision
// ---------------------------------------------------------------------------
module obstacle_collision #(
  parameter int PLAYER_SIZE   = 20,
  parameter int INVULN_CYCLES = 65000000
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [11:0] i_obstacle_x,
  input  logic [11:0] i_obstacle_y,
  input  logic [11:0] i_player_x,
  input  logic [11:0] i_player_y,
  output logic        o_hit
);

  logic [12:0] w_x_end;
  logic [12:0] w_y_end;
  logic        w_in_x;
  logic        w_in_y;
  logic [31:0] r_invuln;

  // Box far edges are 13 bits wide so a player near 4095 does not wrap.
  assign w_x_end = {1'b0, i_player_x} + 13'(PLAYER_SIZE);
  assign w_y_end = {1'b0, i_player_y} + 13'(PLAYER_SIZE);
  assign w_in_x  = (i_obstacle_x != 12'd0) && (i_obstacle_x >= i_player_x) &&
                   ({1'b0, i_obstacle_x} < w_x_end);
  assign w_in_y  = (i_obstacle_y != 12'd0) && (i_obstacle_y >= i_player_y) &&
                   ({1'b0, i_obstacle_y} < w_y_end);

  always_ff @(posedge i_pclk) begin
    if (!i_rst || i_clr) begin
      o_hit    <= 1'b0;
      r_invuln <= '0;
    end else begin
      o_hit <= 1'b0;
      if (i_en && w_in_x && w_in_y && (r_invuln == 32'd0)) begin
        o_hit    <= 1'b1;
        r_invuln <= 32'(INVULN_CYCLES);
      end else if (r_invuln != 32'd0) begin
        r_invuln <= r_invuln - 32'd1;
      end
    end
  end

endmodule

// File: rtl/obstacle_sequencer.sv
// ---------------------------------------------------------------------------
// obstacle_sequencer
// Controller side of the obstacle handshake: picks the next obstacle,
// launches it, waits for it to finish, and tracks lives via collisions.
// Build option: define RANDOM_ORDER_EN for LFSR-based obstacle order;
// otherwise obstacles are launched round-robin starting at 4'b0001.
// Ports:
//   pclk, rst        pixel clock, synchronous active-low reset
//   game_on/menu_on  gameplay screen / menu active (either aborts to IDLE)
//   working_in       per-obstacle busy flags (launch acknowledge)
//   done_in          per-obstacle 1-cycle finish pulses
//   obstacle_x/y     OR-ed obstacle pixel (0 = no pixel)
//   player_x/y       player box top-left corner
//   done_control     1-cycle launch strobe
//   selected         one-hot obstacle code, bits >= NUM_OBST always 0
//   lives            remaining lives
//   hit              1-cycle pulse per accepted collision
//   game_over        high while lives are exhausted
//   timeout_err      sticky flag for a forced WAIT_DONE abort
//   dbg_state        current FSM state (obstacle_pkg::state_t encoding)
//
// Handshake: done_control pulses for one cycle with selected already valid.
// The obstacle acknowledges by raising working_in[idx] (sampled while in
// WAIT_ACK); it finishes with a one-cycle done_in[idx] pulse (sampled in
// WAIT_DONE). Only the bit matching selected is looked at, and selected is
// held from the launch until WAIT_DONE is left.
// ---------------------------------------------------------------------------
module obstacle_sequencer
  import obstacle_pkg::*;
#(
  parameter int NUM_OBST      = 4,
  parameter int PLAYER_SIZE   = 20,
  parameter int START_LIVES   = 3,
  parameter int PAUSE_CYCLES  = 32000000,
  parameter int ACK_TIMEOUT   = 8,
  parameter int DONE_TIMEOUT  = 268435455,
  parameter int INVULN_CYCLES = 65000000
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                game_on,
  input  logic                menu_on,
  input  logic [NUM_OBST-1:0] working_in,
  input  logic [NUM_OBST-1:0] done_in,
  input  logic [11:0]         obstacle_x,
  input  logic [11:0]         obstacle_y,
  input  logic [11:0]         player_x,
  input  logic [11:0]         player_y,
  output logic                done_control,
  output logic [3:0]          selected,
  output logic [2:0]          lives,
  output logic                hit,
  output logic                game_over,
  output logic                timeout_err,
  output logic [2:0]          dbg_state
);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [3:0]  w_next_sel;
  logic        w_abort;
  logic        w_coll_en;
  logic        w_ack;
  logic        w_done;

  assign w_abort   = menu_on || !game_on;
  assign w_coll_en = (r_state != ST_IDLE) && (r_state != ST_GAME_OVER);
  // selected is one-hot, so masking is the same as indexing by its position.
  assign w_ack     = |(working_in & selected[NUM_OBST-1:0]);
  assign w_done    = |(done_in & selected[NUM_OBST-1:0]);
  assign dbg_state = r_state;

`ifdef RANDOM_ORDER_EN
  logic [7:0] r_lfsr;
  logic [1:0] w_rand_idx;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == ST_PAUSE) begin
      r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  // Bump to the next index when the draw repeats the previous obstacle.
  always_comb begin
    w_rand_idx = 2'(r_lfsr % 8'(NUM_OBST));
    if ((selected != SEL_NONE) && (w_rand_idx == onehot_idx(selected))) begin
      w_rand_idx = (w_rand_idx == 2'(NUM_OBST - 1)) ? 2'd0 : w_rand_idx + 2'd1;
    end
    w_next_sel = OBST_LASERS << w_rand_idx;
  end
`else
  localparam logic [3:0] SEL_LAST = 4'(1 << (NUM_OBST - 1));

  always_comb begin
    w_next_sel = ((selected == SEL_NONE) || (selected == SEL_LAST)) ?
                 OBST_LASERS : (selected << 1);
  end
`endif

  obstacle_collision #(
    .PLAYER_SIZE   (PLAYER_SIZE),
    .INVULN_CYCLES (INVULN_CYCLES)
  ) u_collision (
    .i_pclk       (pclk),
    .i_rst        (rst),
    .i_clr        (w_abort),
    .i_en         (w_coll_en),
    .i_obstacle_x (obstacle_x),
    .i_obstacle_y (obstacle_y),
    .i_player_x   (player_x),
    .i_player_y   (player_y),
    .o_hit        (hit)
  );

  always_ff @(posedge pclk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      done_control <= 1'b0;
      selected     <= SEL_NONE;
      lives        <= 3'(START_LIVES);
      game_over    <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (w_abort) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      done_control <= 1'b0;
      selected     <= SEL_NONE;
      if (menu_on) begin
        lives       <= 3'(START_LIVES);
        game_over   <= 1'b0;
        timeout_err <= 1'b0;
      end
    end else begin
      done_control <= 1'b0;
      if (hit && (lives != 3'd0)) lives <= lives - 3'd1;
      // The last life going takes priority over any handshake transition.
      if (hit && (lives <= 3'd1)) begin
        r_state   <= ST_GAME_OVER;
        r_cnt     <= '0;
        game_over <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt   <= '0;
            // A game that ended stays ended until the menu reloads lives.
            r_state <= game_over ? ST_GAME_OVER : ST_PAUSE;
          end
          ST_PAUSE: begin
            if (r_cnt == 32'(PAUSE_CYCLES - 1)) begin
              r_cnt    <= '0;
              selected <= w_next_sel;
              r_state  <= ST_LAUNCH;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          ST_LAUNCH: begin
            done_control <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (w_ack) begin
              r_cnt   <= '0;
              r_state <= ST_WAIT_DONE;
            end else if (r_cnt == 32'(ACK_TIMEOUT - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_LAUNCH;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          ST_WAIT_DONE: begin
            if (w_done) begin
              r_cnt   <= '0;
              r_state <= ST_PAUSE;
            end else if (r_cnt == 32'(DONE_TIMEOUT - 1)) begin
              r_cnt       <= '0;
              timeout_err <= 1'b1;
              r_state     <= ST_PAUSE;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          ST_GAME_OVER: begin
            game_over <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_obstacle_sequencer
// Bench for obstacle_sequencer with shortened timing parameters.
// Build with RANDOM_ORDER_EN to check the LFSR order instead of round-robin.
// ---------------------------------------------------------------------------
module tb_obstacle_sequencer;
  import obstacle_pkg::*;

  localparam int NUM_OBST      = 4;
  localparam int PLAYER_SIZE   = 20;
  localparam int START_LIVES   = 3;
  localparam int PAUSE_CYCLES  = 10;
  localparam int ACK_TIMEOUT   = 8;
  localparam int DONE_TIMEOUT  = 40;
  localparam int INVULN_CYCLES = 20;

  // ---------------- clock / reset / DUT ----------------
  logic        pclk;
  logic        rst;
  logic        game_on;
  logic        menu_on;
  logic [3:0]  working_in;
  logic [3:0]  done_in;
  logic [11:0] obstacle_x;
  logic [11:0] obstacle_y;
  logic [11:0] player_x;
  logic [11:0] player_y;
  logic        done_control;
  logic [3:0]  selected;
  logic [2:0]  lives;
  logic        hit;
  logic        game_over;
  logic        timeout_err;
  logic [2:0]  dbg_state;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  obstacle_sequencer #(
    .NUM_OBST      (NUM_OBST),
    .PLAYER_SIZE   (PLAYER_SIZE),
    .START_LIVES   (START_LIVES),
    .PAUSE_CYCLES  (PAUSE_CYCLES),
    .ACK_TIMEOUT   (ACK_TIMEOUT),
    .DONE_TIMEOUT  (DONE_TIMEOUT),
    .INVULN_CYCLES (INVULN_CYCLES)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .game_on      (game_on),
    .menu_on      (menu_on),
    .working_in   (working_in),
    .done_in      (done_in),
    .obstacle_x   (obstacle_x),
    .obstacle_y   (obstacle_y),
    .player_x     (player_x),
    .player_y     (player_y),
    .done_control (done_control),
    .selected     (selected),
    .lives        (lives),
    .hit          (hit),
    .game_over    (game_over),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Round-robin build: exact code. LFSR build: valid one-hot, not a repeat.
  task automatic check_code(input string name, input logic [3:0] prev, input logic [3:0] rr_exp);
`ifdef RANDOM_ORDER_EN
    check(name, 32'(($onehot(selected) && (selected != prev)) ? 1 : 0), 32'd1);
    if (rr_exp == 4'd0) $display("note: no round-robin reference");
`else
    check(name, 32'(selected), 32'(rr_exp));
    if (prev == 4'hF) $display("note: unexpected previous code");
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Ticks until a launch strobe is seen; n = ticks taken, -1 if none.
  task automatic wait_launch(input int max_ticks, output int n);
    n = -1;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (done_control) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_coll(input logic [11:0] px, input logic [11:0] py,
                            input logic [11:0] ox, input logic [11:0] oy,
                            input logic exp_hit, input string tag);
    menu_on = 1'b1;
    tick();
    menu_on = 1'b0;
    tick();
    player_x = px; player_y = py; obstacle_x = ox; obstacle_y = oy;
    tick();
    check({tag, " hit"}, 32'(hit), 32'(exp_hit));
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    tick();
    check({tag, " lives"}, 32'(lives), exp_hit ? 32'(START_LIVES - 1) : 32'(START_LIVES));
  endtask

  typedef struct {
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] ox;
    logic [11:0] oy;
    logic        exp_hit;
  } coll_vec_t;

  coll_vec_t  vecs[12];
  int         n;
  logic [3:0] cur;
  logic [3:0] prev;
  logic [3:0] code_exp;
  int         model_idx;
  int         pulses;

  initial begin
    vecs[0]  = '{12'd100,  12'd200,  12'd105,  12'd210,  1'b1};
    vecs[1]  = '{12'd100,  12'd200,  12'd119,  12'd200,  1'b1};
    vecs[2]  = '{12'd100,  12'd200,  12'd120,  12'd200,  1'b0};
    vecs[3]  = '{12'd100,  12'd200,  12'd100,  12'd200,  1'b1};
    vecs[4]  = '{12'd100,  12'd200,  12'd99,   12'd210,  1'b0};
    vecs[5]  = '{12'd100,  12'd200,  12'd105,  12'd219,  1'b1};
    vecs[6]  = '{12'd100,  12'd200,  12'd105,  12'd220,  1'b0};
    vecs[7]  = '{12'd0,    12'd0,    12'd0,    12'd0,    1'b0};
    vecs[8]  = '{12'd0,    12'd0,    12'd0,    12'd5,    1'b0};
    vecs[9]  = '{12'd0,    12'd0,    12'd5,    12'd5,    1'b1};
    vecs[10] = '{12'd4090, 12'd4090, 12'd4095, 12'd4095, 1'b1};
    vecs[11] = '{12'd4080, 12'd10,   12'd4095, 12'd9,    1'b0};

    rst = 1'b0; game_on = 1'b0; menu_on = 1'b0;
    working_in = 4'd0; done_in = 4'd0;
    obstacle_x = 12'd0; obstacle_y = 12'd0; player_x = 12'd0; player_y = 12'd0;
    tick();
    tick();
    check("reset done_control", 32'(done_control), 32'd0);
    check("reset selected",     32'(selected),     32'd0);
    check("reset lives",        32'(lives),        32'(START_LIVES));
    check("reset hit",          32'(hit),          32'd0);
    check("reset game_over",    32'(game_over),    32'd0);
    check("reset timeout_err",  32'(timeout_err),  32'd0);
    check("reset state",        32'(dbg_state),    32'(ST_IDLE));
    rst = 1'b1;

    // First launch latency, strobe width, retry on missing ack.
    game_on = 1'b1;
    wait_launch(40, n);
    check("first launch latency", n, PAUSE_CYCLES + 2);
    check_code("first code", 4'd0, OBST_LASERS);
    cur = selected;
    tick();
    check("strobe width", 32'(done_control), 32'd0);
    wait_launch(30, n);
    check("retry gap", n + 1, ACK_TIMEOUT + 1);
    check("retry code", 32'(selected), 32'(cur));

    // Ack, stray done on other bits, then the real done.
    working_in = cur;
    tick();
    working_in = 4'd0;
    check("ack -> wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    done_in = ~cur;
    tick();
    done_in = 4'd0;
    tick();
    check("stray done ignored", 32'(dbg_state), 32'(ST_WAIT_DONE));
    check("selected held", 32'(selected), 32'(cur));
    done_in = cur;
    tick();
    done_in = 4'd0;
    check("done -> pause", 32'(dbg_state), 32'(ST_PAUSE));
    wait_launch(40, n);
    check("relaunch gap", n, PAUSE_CYCLES + 1);
    check_code("second code", cur, OBST_SPIKES);
    cur = selected;

    // Done timeout sets the sticky error and moves on to the next obstacle.
    working_in = cur;
    tick();
    working_in = 4'd0;
    repeat (DONE_TIMEOUT - 1) tick();
    check("timeout_err before", 32'(timeout_err), 32'd0);
    tick();
    check("timeout_err set", 32'(timeout_err), 32'd1);
    check("timeout -> pause", 32'(dbg_state), 32'(ST_PAUSE));
    wait_launch(40, n);
    check("post-timeout gap", n, PAUSE_CYCLES + 1);
    check_code("third code", cur, OBST_BLOCKS);
    cur = selected;

    // One collision held for three cycles: a single hit.
    player_x = 12'd100; player_y = 12'd200; obstacle_x = 12'd105; obstacle_y = 12'd210;
    tick();
    check("hold hit pulse", 32'(hit), 32'd1);
    tick();
    check("hold hit low", 32'(hit), 32'd0);
    check("hold lives", 32'(lives), 32'(START_LIVES - 1));
    tick();
    check("hold invuln", 32'(hit), 32'd0);
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    check("timeout_err sticky", 32'(timeout_err), 32'd1);

    // Menu in the middle of WAIT_DONE.
    wait_launch(20, n);
    working_in = cur;
    tick();
    working_in = 4'd0;
    tick();
    menu_on = 1'b1;
    tick();
    check("menu state", 32'(dbg_state), 32'(ST_IDLE));
    check("menu selected", 32'(selected), 32'd0);
    check("menu lives", 32'(lives), 32'(START_LIVES));
    check("menu timeout_err", 32'(timeout_err), 32'd0);
    menu_on = 1'b0;
    wait_launch(40, n);
    check("post-menu latency", n, PAUSE_CYCLES + 2);
    check_code("post-menu code", 4'd0, OBST_LASERS);

    // Collision table, then random boxes against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      apply_coll(vecs[i].px, vecs[i].py, vecs[i].ox, vecs[i].oy, vecs[i].exp_hit,
                 $sformatf("vec%0d", i));
    end
    for (int i = 0; i < 30; i++) begin
      int   pxi, pyi, oxi, oyi;
      logic e;
      pxi = int'($urandom_range(0, 4095));
      pyi = int'($urandom_range(0, 4095));
      oxi = (pxi + int'($urandom_range(0, 26)) - 3) & 4095;
      oyi = (pyi + int'($urandom_range(0, 26)) - 3) & 4095;
      if ($urandom_range(0, 7) == 0) oxi = 0;
      e = (oxi != 0) && (oyi != 0) && (oxi >= pxi) && (oxi < pxi + PLAYER_SIZE) &&
          (oyi >= pyi) && (oyi < pyi + PLAYER_SIZE);
      apply_coll(12'(pxi), 12'(pyi), 12'(oxi), 12'(oyi), e, $sformatf("rand%0d", i));
    end

    // 100 random-timed launch/ack/done rounds against the order model.
    menu_on = 1'b1;
    tick();
    menu_on = 1'b0;
    model_idx = -1;
    prev = 4'd0;
    wait_launch(40, n);
    check("round first latency", n, PAUSE_CYCLES + 2);
    for (int k = 0; k < 100; k++) begin
      int d, k2, stray_at;
      model_idx = (model_idx + 1) % NUM_OBST;
      exp_q.push_back(4'(1 << model_idx));
      code_exp = exp_q.pop_front();
      check_code($sformatf("round%0d code", k), prev, code_exp);
`ifdef RANDOM_ORDER_EN
      cur = selected;
`else
      cur = code_exp;
`endif
      prev = cur;
      d = int'($urandom_range(0, 6));
      repeat (d) tick();
      working_in = cur;
      tick();
      working_in = 4'd0;
      k2 = int'($urandom_range(0, 30));
      stray_at = int'($urandom_range(0, 30));
      for (int j = 0; j < k2; j++) begin
        done_in = (j == stray_at) ? (4'($urandom_range(1, 15)) & ~cur) : 4'd0;
        tick();
      end
      done_in = cur;
      tick();
      done_in = 4'd0;
      if (k < 99) begin
        wait_launch(40, n);
        check($sformatf("round%0d gap", k), n, PAUSE_CYCLES + 1);
      end
    end

    // Three spaced hits: lives run out, game over, no more launches.
    menu_on = 1'b1;
    tick();
    menu_on = 1'b0;
    tick();
    player_x = 12'd100; player_y = 12'd200;
    obstacle_x = 12'd105; obstacle_y = 12'd210;
    tick();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    repeat (INVULN_CYCLES + 5) tick();
    check("go lives 2", 32'(lives), 32'd2);
    obstacle_x = 12'd119; obstacle_y = 12'd200;
    tick();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    repeat (INVULN_CYCLES + 5) tick();
    check("go lives 1", 32'(lives), 32'd1);
    obstacle_x = 12'd105; obstacle_y = 12'd210;
    tick();
    check("go last hit", 32'(hit), 32'd1);
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    tick();
    check("go lives 0", 32'(lives), 32'd0);
    check("go flag", 32'(game_over), 32'd1);
    check("go state", 32'(dbg_state), 32'(ST_GAME_OVER));
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done_control) pulses++;
    end
    check("go no launches", pulses, 0);
    check("go flag held", 32'(game_over), 32'd1);
    menu_on = 1'b1;
    tick();
    check("go menu clears", 32'(game_over), 32'd0);
    check("go menu lives", 32'(lives), 32'(START_LIVES));
    menu_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
